float_packer: RTL

FLOAT_PACKER -- requirements
Module: float_packer

---
 rtl/fp_pkg.sv | 21 ++
 rtl/float_packer_if.sv | 32 +++
 rtl/float_pack_word.sv | 38 +++
 rtl/float_packer.sv | 100 ++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg -- shared constants and types for the float packer.
//   EXP_MAX / EXP_MIN : biased exponent values that mark overflow and underflow/zero
//   FLG_*             : bit positions inside the 3-bit flags field {ovf, unf, zero}
//   fifo_entry_t      : one packed result as it is stored in the output FIFO
package fp_pkg;

   localparam logic [7:0] EXP_MAX = 8'hFF;
   localparam logic [7:0] EXP_MIN = 8'h00;

   localparam int FLG_OVF  = 2;
   localparam int FLG_UNF  = 1;
   localparam int FLG_ZERO = 0;

   localparam int FIFO_DEPTH = 2;

   typedef struct packed {
      logic [31:0] word;
      logic [2:0]  flags;
   } fifo_entry_t;

endpackage

// File: rtl/float_packer_if.sv
// float_packer_if -- valid/ready streams around the float packer.
//   in_*  : unpacked adder result (sign, biased exponent, magnitude with hidden bit,
//           exponent error flag) with in_valid/in_ready handshake
//   out_* : packed IEEE-754 single word plus {ovf, unf, zero} flags with
//           out_valid/out_ready handshake
//   slave modport  : the packer side
//   master modport : the producer/consumer side
interface float_packer_if;

   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [23:0] in_abs;
   logic        in_err;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [2:0]  out_flags;

   modport slave (
      input  in_valid, in_sign, in_exp, in_abs, in_err, out_ready,
      output in_ready, out_valid, out_word, out_flags
   );

   modport master (
      output in_valid, in_sign, in_exp, in_abs, in_err, out_ready,
      input  in_ready, out_valid, out_word, out_flags
   );

endinterface

// File: rtl/float_pack_word.sv
// float_pack_word -- combinational packing of an unpacked adder result.
//   sign, exp[7:0], abs[23:0], err : unpacked result from the adder
//   word[31:0]                     : IEEE-754 single-precision encoding
//   flags[2:0]                     : {ovf, unf, zero}
// An all-ones exponent always packs to infinity; an all-zero exponent packs to a
// signed zero, flagged as underflow when err is set and as a plain zero otherwise.
module float_pack_word
   import fp_pkg::*;
(
   input  logic        sign,
   input  logic [7:0]  exp,
   input  logic [23:0] abs,
   input  logic        err,
   output logic [31:0] word,
   output logic [2:0]  flags
);

   // The hidden bit is implied by the exponent field and is not checked.
   logic unused_hidden_bit;
   assign unused_hidden_bit = abs[23];

   always_comb begin
      word  = {sign, exp, abs[22:0]};
      flags = '0;
      if (exp == EXP_MAX) begin
         word           = {sign, EXP_MAX, 23'd0};
         flags[FLG_OVF] = 1'b1;
      end else if (exp == EXP_MIN) begin
         word = {sign, 31'd0};
         if (err) begin
            flags[FLG_UNF] = 1'b1;
         end else begin
            flags[FLG_ZERO] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/float_packer.sv
// float_packer -- packs adder results into IEEE-754 words behind a 2-entry FIFO
// and keeps saturating overflow/underflow counters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : input and output valid/ready streams
//   clr_cnt           : synchronous clear of both counters (beats an increment)
//   ovf_cnt, unf_cnt  : saturating counts of accepted overflow / underflow results
// Packing happens at accept time so the FIFO only ever stores finished words.
module float_packer
   import fp_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   float_packer_if.slave    bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] ovf_cnt,
   output logic [CNT_W-1:0] unf_cnt
);

   logic [1:0]  count_reg;
   logic        wr_ptr_reg;
   logic        rd_ptr_reg;
   logic        accept;
   logic        pop;
   fifo_entry_t new_entry;
   fifo_entry_t entry_q [FIFO_DEPTH];

   float_pack_word u_pack (
      .sign  (bus.in_sign),
      .exp   (bus.in_exp),
      .abs   (bus.in_abs),
      .err   (bus.in_err),
      .word  (new_entry.word),
      .flags (new_entry.flags)
   );

   // Ready depends only on occupancy so there is no combinational path
   // from out_ready back to in_ready.
   assign bus.in_ready  = (count_reg < 2'd2);
   assign bus.out_valid = (count_reg != 2'd0);
   assign accept        = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         fifo_entry_t entry_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_reg <= '0;
            end else if (accept && (wr_ptr_reg == 1'(gi))) begin
               entry_reg <= new_entry;
            end
         end
         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   assign bus.out_word  = entry_q[rd_ptr_reg].word;
   assign bus.out_flags = entry_q[rd_ptr_reg].flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({accept, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt <= '0;
         unf_cnt <= '0;
      end else if (clr_cnt) begin
         ovf_cnt <= '0;
         unf_cnt <= '0;
      end else begin
         if (accept && new_entry.flags[FLG_OVF] && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
         end
         if (accept && new_entry.flags[FLG_UNF] && (unf_cnt != '1)) begin
            unf_cnt <= unf_cnt + 1'b1;
         end
      end
   end

endmodule
